// File: rtl/rv32i_sim_monitor.sv
// End-of-run monitor: watches the fetched instruction stream and flags halt-loop or timeout.
// Build option: define MON_EBREAK_EN to make a fetched ebreak halt the run immediately (cause 10).
module rv32i_sim_monitor #(
    parameter logic [31:0] HALT_INSN      = 32'h0000_006F,
    parameter int          HALT_REPEAT    = 5,
    parameter int          TIMEOUT_CYCLES = 1000000,
    parameter int          CNT_W          = 32
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic             enable_i,
    input  logic             inst_valid_i,
    input  logic [31:0]      inst_i,
    output logic             halt_o,
    output logic             timeout_o,
    output logic             done_o,
    output logic [1:0]       halt_cause_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] inst_cnt_o,
    output logic [CNT_W-1:0] halt_cycle_o
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_HALTED  = 2'd2;
    localparam logic [1:0] S_TIMEOUT = 2'd3;

    localparam logic [1:0] C_NONE    = 2'b00;
    localparam logic [1:0] C_LOOP    = 2'b01;
    localparam logic [1:0] C_EBREAK  = 2'b10;
    localparam logic [1:0] C_TIMEOUT = 2'b11;

    localparam logic [7:0]       REPEAT_LIM = 8'(HALT_REPEAT);
    localparam bit               TO_EN      = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       r_state;
    logic [7:0]       r_match;
    logic             r_halt;
    logic             r_timeout;
    logic [1:0]       r_cause;
    logic [CNT_W-1:0] r_cycle;
    logic [CNT_W-1:0] r_inst;
    logic [CNT_W-1:0] r_snap;

    logic [7:0] w_match_nxt;
    logic       w_loop_hit;
    logic       w_to_hit;
    logic       w_ebreak;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Streak of consecutive matching fetches; bubbles leave it untouched.
    always_comb begin
        w_match_nxt = r_match;
        if (inst_valid_i) begin
            w_match_nxt = (inst_i == HALT_INSN) ? r_match + 8'd1 : 8'd0;
        end
    end

    assign w_loop_hit = (w_match_nxt == REPEAT_LIM);
    assign w_to_hit   = TO_EN && (r_cycle == TO_LAST);

`ifdef MON_EBREAK_EN
    localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;
    assign w_ebreak = inst_valid_i && (inst_i == EBREAK_INSN);
`else
    assign w_ebreak = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_state   <= S_IDLE;
            r_match   <= 8'd0;
            r_halt    <= 1'b0;
            r_timeout <= 1'b0;
            r_cause   <= C_NONE;
            r_cycle   <= '0;
            r_inst    <= '0;
            r_snap    <= '0;
        end else if (!enable_i) begin
            r_state   <= S_IDLE;
            r_match   <= 8'd0;
            r_halt    <= 1'b0;
            r_timeout <= 1'b0;
            r_cause   <= C_NONE;
            r_cycle   <= '0;
            r_inst    <= '0;
            r_snap    <= '0;
        end else begin
            case (r_state)
                // Counters are already zero here, so the first RUN cycle starts from 0.
                S_IDLE: r_state <= S_RUN;
                S_RUN: begin
                    r_cycle <= sat_inc(r_cycle);
                    if (inst_valid_i) begin
                        r_inst <= sat_inc(r_inst);
                    end
                    r_match <= w_match_nxt;
                    // Priority: ebreak, then halt loop, then timeout.
                    if (w_ebreak) begin
                        r_state <= S_HALTED;
                        r_halt  <= 1'b1;
                        r_cause <= C_EBREAK;
                        r_snap  <= r_cycle;
                    end else if (w_loop_hit) begin
                        r_state <= S_HALTED;
                        r_halt  <= 1'b1;
                        r_cause <= C_LOOP;
                        r_snap  <= r_cycle;
                    end else if (w_to_hit) begin
                        r_state   <= S_TIMEOUT;
                        r_timeout <= 1'b1;
                        r_cause   <= C_TIMEOUT;
                        r_snap    <= r_cycle;
                    end
                end
                default: r_state <= r_state;
            endcase
        end
    end

    assign halt_o       = r_halt;
    assign timeout_o    = r_timeout;
    assign done_o       = r_halt | r_timeout;
    assign halt_cause_o = r_cause;
    assign cycle_cnt_o  = r_cycle;
    assign inst_cnt_o   = r_inst;
    assign halt_cycle_o = r_snap;

endmodule

// File: tb/tb_rv32i_sim_monitor.sv
// Bench for rv32i_sim_monitor: directed vector table, hand sequences, and a randomized run vs a reference model.
module tb_rv32i_sim_monitor;

    localparam logic [31:0] HALT = 32'h0000_006F;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] EBRK = 32'h0010_0073;
    localparam int REPEAT = 5;
    localparam int TO     = 20;
`ifdef MON_EBREAK_EN
    localparam bit EB = 1'b1;
`else
    localparam bit EB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn, en, v;
    logic [31:0] ins;
    logic        halt_o, timeout_o, done_o;
    logic [1:0]  halt_cause_o;
    logic [31:0] cycle_cnt_o, inst_cnt_o, halt_cycle_o;

    int tests = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv32i_sim_monitor #(
        .HALT_INSN(HALT), .HALT_REPEAT(REPEAT), .TIMEOUT_CYCLES(TO), .CNT_W(32)
    ) dut (
        .clk_i(clk), .resetn_i(resetn), .enable_i(en), .inst_valid_i(v), .inst_i(ins),
        .halt_o(halt_o), .timeout_o(timeout_o), .done_o(done_o), .halt_cause_o(halt_cause_o),
        .cycle_cnt_o(cycle_cnt_o), .inst_cnt_o(inst_cnt_o), .halt_cycle_o(halt_cycle_o)
    );

    typedef struct {
        logic        en;
        logic        v;
        logic [31:0] ins;
        int          n;
        logic        halt;
        logic        to;
        logic [1:0]  cause;
        int          cyc;
        int          icnt;
        int          hc;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic e, input logic vv, input logic [31:0] i, input int n,
                                input logic h, input logic t, input logic [1:0] c,
                                input int cyc, input int icnt, input int hc);
        vec_t r;
        r.en = e; r.v = vv; r.ins = i; r.n = n;
        r.halt = h; r.to = t; r.cause = c; r.cyc = cyc; r.icnt = icnt; r.hc = hc;
        tbl.push_back(r);
    endfunction

    task automatic check(input string name, input logic h, input logic t, input logic [1:0] c,
                         input int cyc, input int icnt, input int hc);
        tests++;
        if (halt_o !== h || timeout_o !== t || done_o !== (h | t) || halt_cause_o !== c ||
            cycle_cnt_o !== 32'(cyc) || inst_cnt_o !== 32'(icnt) || halt_cycle_o !== 32'(hc)) begin
            errors++;
            $display("FAIL %s: got halt=%b to=%b done=%b cause=%b cyc=%0d inst=%0d hc=%0d, want halt=%b to=%b done=%b cause=%b cyc=%0d inst=%0d hc=%0d",
                     name, halt_o, timeout_o, done_o, halt_cause_o, cycle_cnt_o, inst_cnt_o, halt_cycle_o,
                     h, t, h | t, c, cyc, icnt, hc);
        end
    endtask

    // Reference model: armed flag, terminal cause, run length of matching fetches.
    bit m_armed;
    int m_cause, m_cyc, m_ins, m_streak, m_snap;

    function automatic void m_clear();
        m_armed = 0; m_cause = 0; m_cyc = 0; m_ins = 0; m_streak = 0; m_snap = 0;
    endfunction

    function automatic void m_step(input bit e, input bit vv, input logic [31:0] i);
        int c;
        c = 0;
        if (!e) begin
            m_clear();
        end else if (!m_armed) begin
            m_armed = 1;
        end else if (m_cause == 0) begin
            if (vv) m_streak = (i == HALT) ? m_streak + 1 : 0;
            if (EB && vv && i == EBRK) c = 2;
            else if (m_streak >= REPEAT) c = 1;
            else if (m_cyc == TO - 1) c = 3;
            if (c != 0) begin
                m_cause = c;
                m_snap  = m_cyc;
            end
            m_cyc++;
            if (vv) m_ins++;
        end
    endfunction

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; en = 1'b0; v = 1'b0; ins = NOP;

        // basic halt after 10 nops + 5 loop fetches
        add(1,0,NOP,1,  0,0,0, 0,0,0);
        add(1,1,NOP,10, 0,0,0, 10,10,0);
        add(1,1,HALT,4, 0,0,0, 14,14,0);
        add(1,1,HALT,1, 1,0,1, 15,15,14);
        add(1,1,HALT,3, 1,0,1, 15,15,14);
        add(0,0,NOP,1,  0,0,0, 0,0,0);
        // broken streak
        add(1,0,NOP,1,  0,0,0, 0,0,0);
        add(1,1,HALT,4, 0,0,0, 4,4,0);
        add(1,1,NOP,1,  0,0,0, 5,5,0);
        add(1,1,HALT,4, 0,0,0, 9,9,0);
        add(1,1,HALT,1, 1,0,1, 10,10,9);
        add(0,0,NOP,1,  0,0,0, 0,0,0);
        // bubbles between matches (bubble carries a non-matching word)
        add(1,0,NOP,1,  0,0,0, 0,0,0);
        for (int j = 0; j < 5; j++) begin
            add(1,1,HALT,1, (j == 4), 0, (j == 4) ? 2'b01 : 2'b00, 2*j+1, j+1, (j == 4) ? 8 : 0);
            if (j < 4) add(1,0,NOP,1, 0,0,0, 2*j+2, j+1, 0);
        end
        add(0,0,NOP,1,  0,0,0, 0,0,0);
        // timeout and freeze
        add(1,0,NOP,1,  0,0,0, 0,0,0);
        add(1,1,NOP,19, 0,0,0, 19,19,0);
        add(1,1,NOP,1,  0,1,3, 20,20,19);
        add(1,1,HALT,5, 0,1,3, 20,20,19);
        add(0,0,NOP,1,  0,0,0, 0,0,0);
        // halt and timeout on the same edge
        add(1,0,NOP,1,  0,0,0, 0,0,0);
        add(1,1,NOP,15, 0,0,0, 15,15,0);
        add(1,1,HALT,4, 0,0,0, 19,19,0);
        add(1,1,HALT,1, 1,0,1, 20,20,19);
        add(0,0,NOP,1,  0,0,0, 0,0,0);
        // fetches while idle are ignored, including the arming edge
        add(0,1,HALT,6, 0,0,0, 0,0,0);
        add(1,1,HALT,1, 0,0,0, 0,0,0);
        add(1,1,HALT,4, 0,0,0, 4,4,0);
        add(1,1,HALT,1, 1,0,1, 5,5,4);
        add(0,0,NOP,1,  0,0,0, 0,0,0);
        // ebreak in the middle of a streak
        add(1,0,NOP,1,  0,0,0, 0,0,0);
        add(1,1,HALT,4, 0,0,0, 4,4,0);
        add(1,1,EBRK,1, EB,0, EB ? 2'b10 : 2'b00, 5,5, EB ? 4 : 0);
        add(1,1,HALT,4, EB,0, EB ? 2'b10 : 2'b00, EB ? 5 : 9, EB ? 5 : 9, EB ? 4 : 0);
        add(1,1,HALT,1, 1,0, EB ? 2'b10 : 2'b01, EB ? 5 : 10, EB ? 5 : 10, EB ? 4 : 9);
        add(0,0,NOP,1,  0,0,0, 0,0,0);

        repeat (2) @(posedge clk);
        #1 check("reset_state", 0,0,0, 0,0,0);
        @(negedge clk) resetn = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            en = tbl[i].en; v = tbl[i].v; ins = tbl[i].ins;
            repeat (tbl[i].n) @(posedge clk);
            #1 check($sformatf("vec%0d", i), tbl[i].halt, tbl[i].to, tbl[i].cause,
                     tbl[i].cyc, tbl[i].icnt, tbl[i].hc);
        end

        // reset mid-streak must drop the partial match
        en = 1'b1; v = 1'b0; ins = NOP;
        @(posedge clk); #1 check("rst_arm", 0,0,0, 0,0,0);
        v = 1'b1; ins = HALT;
        repeat (3) @(posedge clk); #1 check("rst_3match", 0,0,0, 3,3,0);
        #2 resetn = 1'b0;
        #1 check("rst_async", 0,0,0, 0,0,0);
        @(negedge clk) resetn = 1'b1;
        @(posedge clk); #1 check("rst_rearm", 0,0,0, 0,0,0);
        repeat (2) @(posedge clk); #1 check("rst_2match", 0,0,0, 2,2,0);
        repeat (3) @(posedge clk); #1 check("rst_halt", 1,0,1, 5,5,4);
        en = 1'b0;
        @(posedge clk); #1 check("en_toggle_clear", 0,0,0, 0,0,0);
        en = 1'b1; v = 1'b0;
        @(posedge clk); #1 check("en_rearm", 0,0,0, 0,0,0);

        // randomized run against the model
        resetn = 1'b0; en = 1'b0; v = 1'b0;
        m_clear();
        @(negedge clk) resetn = 1'b1;
        for (int k = 0; k < 800; k++) begin
            int r;
            en = ($urandom_range(0, 24) != 0);
            v  = ($urandom_range(0, 3) != 0);
            r  = $urandom_range(0, 9);
            if (r <= 5)      ins = HALT;
            else if (r == 6) ins = NOP;
            else if (r == 7) ins = EBRK;
            else             ins = $urandom;
            @(posedge clk);
            m_step(en, v, ins);
            #1 check($sformatf("rand%0d", k), (m_cause == 1 || m_cause == 2), (m_cause == 3),
                     2'(m_cause), m_cyc, m_ins, m_snap);
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
